// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative accumulator-datapath ALU.
// The default width has to match the register file it sits downstream of.
package alu_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_MUL = 3'b110,
    OP_MOV = 3'b111
  } op_t;

  typedef enum logic {
    ACC = 1'b0,
    REG = 1'b1
  } dest_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shiftadd.sv
// Unsigned shift-add multiplier datapath; one multiplier bit is consumed per step.
// product shows the partial product after the current step, so the caller can capture it on that edge.
module alu_shiftadd
  import alu_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [2*W-1:0] product
);

  logic [2*W-1:0] partial;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;

  assign product = mplier[0] ? (partial + mcand) : partial;

  always_ff @(posedge CLK) begin
    if (reset) begin
      partial <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (load) begin
      partial <= '0;
      mcand   <= {{W{1'b0}}, multiplicand};
      mplier  <= multiplier;
    end else if (step) begin
      partial <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Iterative ALU: single-step logic ops, multi-step shifts and shift-add multiply,
// with a start/busy/done handshake and write-back strobes selecting register or accumulator.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         dest,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] reg_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero,
  output logic         wr_reg,
  output logic         wr_acc
);

  state_t         state;
  logic [CW-1:0]  count;
  logic [CW-1:0]  steps_m1;
  op_t            op_q;
  dest_t          dest_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   result_nx;
  logic           carry_nx;
  logic [2*W-1:0] product;
  logic           accept;

  assign accept = (state == IDLE) && start;

  alu_shiftadd #(.W(W)) u_shiftadd (
    .CLK          (CLK),
    .reset        (reset),
    .load         (accept),
    .step         ((state == RUN) && (op_q == OP_MUL)),
    .multiplicand (acc_in),
    .multiplier   (reg_in),
    .product      (product)
  );

  // A shift amount of zero still takes one step, which leaves A untouched.
  always_comb begin
    steps_m1 = '0;
    case (op_t'(op))
      OP_SHL, OP_SHR: steps_m1 = (reg_in[2:0] == 3'd0) ? '0 : (CW'(reg_in[2:0]) - CW'(1));
      OP_MUL:         steps_m1 = CW'(W - 1);
      default:        steps_m1 = '0;
    endcase
  end

  always_comb begin
    result_nx = result;
    carry_nx  = carry_out;
    case (op_q)
      OP_ADD: {carry_nx, result_nx} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        result_nx = a_q - b_q;
        carry_nx  = (a_q >= b_q);
      end
      OP_AND: begin
        result_nx = a_q & b_q;
        carry_nx  = 1'b0;
      end
      OP_XOR: begin
        result_nx = a_q ^ b_q;
        carry_nx  = 1'b0;
      end
      OP_MOV: begin
        result_nx = b_q;
        carry_nx  = 1'b0;
      end
      OP_SHL: if (b_q[2:0] != 3'd0) {carry_nx, result_nx} = {result, 1'b0};
      OP_SHR: if (b_q[2:0] != 3'd0) {result_nx, carry_nx} = {1'b0, result};
      OP_MUL: begin
        result_nx = product[W-1:0];
        carry_nx  = |product[2*W-1:W];
      end
      default: begin
        result_nx = result;
        carry_nx  = carry_out;
      end
    endcase
  end

  // result is preloaded with A on accept so shifts can work in place.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      op_q      <= OP_ADD;
      dest_q    <= ACC;
      a_q       <= '0;
      b_q       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            count     <= steps_m1;
            op_q      <= op_t'(op);
            dest_q    <= dest_t'(dest);
            a_q       <= acc_in;
            b_q       <= reg_in;
            result    <= acc_in;
            carry_out <= 1'b0;
          end
        end
        RUN: begin
          result    <= result_nx;
          carry_out <= carry_nx;
          if (count == '0) begin
            state <= DONE;
          end else begin
            count <= count - CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign wr_reg = done && (dest_q == REG);
  assign wr_acc = done && (dest_q == ACC);
  assign zero   = (result == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic       CLK;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic       dest;
  logic [7:0] acc_in;
  logic [7:0] reg_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;
  logic       wr_reg;
  logic       wr_acc;

  int tests;
  int failed;

  alu_seq #(.W(8), .CW(4)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .dest      (dest),
    .acc_in    (acc_in),
    .reg_in    (reg_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .wr_reg    (wr_reg),
    .wr_acc    (wr_acc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: {carry, result} straight from the arithmetic definition of each op.
  function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] t;
    int n;
    n = int'(b[2:0]);
    case (o)
      OP_ADD: begin
        t = 16'(a) + 16'(b);
        return {t[8], t[7:0]};
      end
      OP_SUB: return {(a >= b), 8'(a - b)};
      OP_AND: return {1'b0, a & b};
      OP_XOR: return {1'b0, a ^ b};
      OP_MOV: return {1'b0, b};
      OP_SHL: begin
        if (n == 0) return {1'b0, a};
        t = 16'(a) << n;
        return {t[8], t[7:0]};
      end
      OP_SHR: begin
        if (n == 0) return {1'b0, a};
        t = {a, 8'h00} >> n;
        return {t[7], t[15:8]};
      end
      default: begin
        t = 16'(a) * 16'(b);
        return {(t[15:8] != 8'h00), t[7:0]};
      end
    endcase
  endfunction

  function automatic int steps(input logic [2:0] o, input logic [7:0] b);
    if (o == OP_SHL || o == OP_SHR) return (b[2:0] == 3'd0) ? 1 : int'(b[2:0]);
    if (o == OP_MUL) return 8;
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called just after a negedge with the ALU idle; noisy=1 random starts while busy,
  // noisy=2 starts sampled at edges 2 and 5; any noisy mode also raises start in the done cycle.
  task automatic applyStimulus(input logic [2:0] t_op, input logic [7:0] a, input logic [7:0] b,
                               input logic d, input int noisy);
    logic [8:0] exp;
    int s;
    int k;
    bit seen;
    exp = model(t_op, a, b);
    s = steps(t_op, b);
    op = t_op;
    acc_in = a;
    reg_in = b;
    dest = d;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    op = 3'($urandom);
    acc_in = 8'($urandom);
    reg_in = 8'($urandom);
    dest = 1'($urandom);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checkOutput("busy_run", 32'(busy), 32'd1);
        checkOutput("wr_run", 32'({wr_reg, wr_acc}), 32'd0);
        if (noisy == 1) start = 1'($urandom_range(0, 1));
        else if (noisy == 2) start = (k == 1 || k == 4);
        else start = 1'b0;
        @(posedge CLK);
        k++;
      end
    end
    checkOutput("latency", 32'(k), 32'(s));
    checkOutput("result", 32'(result), 32'(exp[7:0]));
    checkOutput("carry", 32'(carry_out), 32'(exp[8]));
    checkOutput("zero", 32'(zero), 32'(exp[7:0] == 8'h00));
    checkOutput("wr_reg", 32'(wr_reg), 32'(d));
    checkOutput("wr_acc", 32'(wr_acc), 32'(!d));
    checkOutput("busy_done", 32'(busy), 32'd1);
    start = (noisy != 0);
    @(negedge CLK);
    start = 1'b0;
    checkOutput("done_drop", 32'({busy, done, wr_reg, wr_acc}), 32'd0);
    checkOutput("result_held", 32'({carry_out, result}), 32'(exp));
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b1;
    start = 1'b1;
    op = OP_ADD;
    dest = 1'b0;
    acc_in = 8'h11;
    reg_in = 8'h22;
    repeat (3) @(negedge CLK);
    checkOutput("reset_state", 32'({busy, done, wr_reg, wr_acc, carry_out}), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_zero", 32'(zero), 32'd1);
    reset = 1'b0;
    start = 1'b0;
    @(negedge CLK);
    checkOutput("idle_after_reset", 32'(busy), 32'd0);

    applyStimulus(OP_ADD, 8'hF0, 8'h20, 1'b0, 0);
    applyStimulus(OP_SUB, 8'h05, 8'h07, 1'b1, 0);
    applyStimulus(OP_SUB, 8'h07, 8'h07, 1'b0, 0);
    applyStimulus(OP_SHL, 8'h81, 8'h03, 1'b1, 0);
    applyStimulus(OP_SHR, 8'h01, 8'h01, 1'b0, 0);
    applyStimulus(OP_SHL, 8'hA5, 8'h08, 1'b0, 0);
    applyStimulus(OP_MUL, 8'h0D, 8'h15, 1'b1, 2);
    applyStimulus(OP_MUL, 8'h0F, 8'h0F, 1'b0, 1);
    applyStimulus(OP_AND, 8'hCC, 8'hAA, 1'b1, 0);
    applyStimulus(OP_XOR, 8'hCC, 8'hAA, 1'b0, 0);
    applyStimulus(OP_MOV, 8'h12, 8'h9E, 1'b1, 0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
    end

    // Abort a multiply with reset sampled at edge 4.
    op = OP_MUL;
    acc_in = 8'h0D;
    reg_in = 8'h15;
    dest = 1'b1;
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("abort_pre_done", 32'({done, busy}), 32'd1);
      @(negedge CLK);
    end
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    checkOutput("abort_flags", 32'({busy, done, wr_reg, wr_acc}), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_zero", 32'(zero), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkOutput("abort_no_done", 32'({busy, done, wr_reg, wr_acc}), 32'd0);
    end
    applyStimulus(OP_ADD, 8'h01, 8'h01, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
